writeback_arbiter: RTL and testbench

//  Write-side master for register_file: merges ALU results and load results into one registered port.

---
 rtl/writeback_arbiter.sv | 112 +++++++++++
 tb/tb_writeback_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
// Write-side master for the register file. Merges ALU results and load
// results into a single registered write port, at most one write per cycle.
// ALU results win unless the load FIFO is full; loads drain in arrival order.
// Optional feature macro: WB_BYPASS_EN adds decode-side forwarding hit flags.
module writeback_arbiter #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alu_valid_i,
    input  logic [4:0]                 alu_rd_i,
    input  logic [DWIDTH-1:0]          alu_data_i,
    output logic                       alu_ready_o,
    input  logic                       ld_valid_i,
    input  logic [4:0]                 ld_rd_i,
    input  logic [DWIDTH-1:0]          ld_data_i,
    output logic                       ld_ready_o,
    output logic [4:0]                 rd_o,
    output logic [DWIDTH-1:0]          datawb_o,
    output logic                       regwren_o,
`ifdef WB_BYPASS_EN
    input  logic [4:0]                 rs1_i,
    input  logic [4:0]                 rs2_i,
    output logic                       fwd1_o,
    output logic                       fwd2_o,
`endif
    output logic [$clog2(DEPTH):0]     fifo_count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic [4:0]        mem_rd_q   [DEPTH];
    logic [DWIDTH-1:0] mem_data_q [DEPTH];

    logic              full, empty;
    logic              push, pop, alu_issue, issue;
    logic [4:0]        issue_rd;
    logic [DWIDTH-1:0] issue_data;

    // Issue selection: a full FIFO preempts the ALU so loads cannot starve.
    always_comb begin
        full        = (count_q == CW'(DEPTH));
        empty       = (count_q == '0);
        ld_ready_o  = !full;
        alu_ready_o = !full;
        push        = ld_valid_i && !full;
        alu_issue   = alu_valid_i && !full;
        pop         = full || (!alu_valid_i && !empty);
        issue       = pop || alu_issue;
        issue_rd    = alu_rd_i;
        issue_data  = alu_data_i;
        if (pop) begin
            issue_rd   = mem_rd_q[rd_ptr_q];
            issue_data = mem_data_q[rd_ptr_q];
        end
        // Push is never allowed when full, so push and pop together keep count.
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        fifo_count_o = count_q;
    end

    // FIFO pointers, occupancy and the registered write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_o      <= '0;
            datawb_o  <= '0;
            regwren_o <= 1'b0;
        end else begin
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            // x0 writes are consumed but never enabled.
            regwren_o <= issue && (issue_rd != 5'd0);
            if (issue) begin
                rd_o     <= issue_rd;
                datawb_o <= issue_data;
            end
        end
    end

    // FIFO storage; contents are don't-care after reset so no reset is applied.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_rd_q[wr_ptr_q]   <= ld_rd_i;
            mem_data_q[wr_ptr_q] <= ld_data_i;
        end
    end

`ifdef WB_BYPASS_EN
    // Read hits the write currently on the register-file port.
    always_comb begin
        fwd1_o = regwren_o && (rd_o == rs1_i) && (rs1_i != 5'd0);
        fwd2_o = regwren_o && (rd_o == rs2_i) && (rs2_i != 5'd0);
    end
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench for writeback_arbiter: a queue-based reference model
// predicts each cycle's write port; a separate monitor compares it.
module tb_writeback_arbiter;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          alu_valid = 1'b0;
    logic [4:0]    alu_rd = '0;
    logic [DW-1:0] alu_data = '0;
    logic          alu_ready;
    logic          ld_valid = 1'b0;
    logic [4:0]    ld_rd = '0;
    logic [DW-1:0] ld_data = '0;
    logic          ld_ready;
    logic [4:0]    rd;
    logic [DW-1:0] datawb;
    logic          regwren;
    logic [CW-1:0] fifo_count;
    logic [4:0]    rs1 = '0;
    logic [4:0]    rs2 = '0;
    logic          fwd1, fwd2;

    writeback_arbiter #(.DWIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_valid_i  (alu_valid),
        .alu_rd_i     (alu_rd),
        .alu_data_i   (alu_data),
        .alu_ready_o  (alu_ready),
        .ld_valid_i   (ld_valid),
        .ld_rd_i      (ld_rd),
        .ld_data_i    (ld_data),
        .ld_ready_o   (ld_ready),
        .rd_o         (rd),
        .datawb_o     (datawb),
        .regwren_o    (regwren),
`ifdef WB_BYPASS_EN
        .rs1_i        (rs1),
        .rs2_i        (rs2),
        .fwd1_o       (fwd1),
        .fwd2_o       (fwd2),
`endif
        .fifo_count_o (fifo_count)
    );

`ifndef WB_BYPASS_EN
    assign fwd1 = 1'b0;
    assign fwd2 = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [4:0]    rd;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        logic [4:0]    rd;
        logic [DW-1:0] data;
    } ld_t;

    wr_t exp_q[$];
    ld_t lq[$];
    logic [4:0]    last_rd   = '0;
    logic [DW-1:0] last_data = '0;
    int n_cmp = 0;
    int n_err = 0;
    bit started = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive at negedge, check readiness, advance the model.
    task automatic step(input logic av, input logic [4:0] ar, input logic [DW-1:0] ad,
                        input logic lv, input logic [4:0] lr, input logic [DW-1:0] ldd,
                        output logic alu_acc);
        int  sz;
        bit  is_full;
        wr_t e;
        ld_t h;
        @(negedge clk);
        alu_valid = av; alu_rd = ar; alu_data = ad;
        ld_valid  = lv; ld_rd  = lr; ld_data  = ldd;
        #1;
        sz      = lq.size();
        is_full = (sz == DEPTH);
        chk("alu_ready", 64'(alu_ready), 64'(!is_full));
        chk("ld_ready", 64'(ld_ready), 64'(!is_full));
        chk("fifo_count", 64'(fifo_count), 64'(sz));
        alu_acc = av && !is_full;
        e.we = 1'b0; e.rd = last_rd; e.data = last_data;
        if (is_full || (!av && sz > 0)) begin
            h = lq.pop_front();
            e.rd = h.rd; e.data = h.data; e.we = (h.rd != 0);
        end else if (av) begin
            e.rd = ar; e.data = ad; e.we = (ar != 0);
        end
        if (lv && !is_full) begin
            h.rd = lr; h.data = ldd;
            lq.push_back(h);
        end
        last_rd = e.rd; last_data = e.data;
        exp_q.push_back(e);
    endtask

    // Monitor: each cycle the write port must match the oldest prediction.
    initial begin
        wr_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("regwren", 64'(regwren), 64'(e.we));
                chk("rd", 64'(rd), 64'(e.rd));
                chk("datawb", 64'(datawb), 64'(e.data));
`ifdef WB_BYPASS_EN
                chk("fwd1", 64'(fwd1), 64'(e.we && e.rd == rs1 && rs1 != 0));
                chk("fwd2", 64'(fwd2), 64'(e.we && e.rd == rs2 && rs2 != 0));
`endif
            end else if (started) begin
                chk("regwren_idle", 64'(regwren), 64'(0));
            end
        end
    end

    initial begin
        logic          acc;
        logic          pend;
        logic [4:0]    prd;
        logic [DW-1:0] pdat;
        int            guard;

        // Reset held, then released.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_regwren", 64'(regwren), 64'(0));
        chk("rst_rd", 64'(rd), 64'(0));
        chk("rst_datawb", 64'(datawb), 64'(0));
        chk("rst_count", 64'(fifo_count), 64'(0));
        chk("rst_ld_ready", 64'(ld_ready), 64'(1));
        chk("rst_alu_ready", 64'(alu_ready), 64'(1));
        started = 1'b1;

        // Single ALU write, latency one.
        step(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, acc);
        step(0, 0, 0, 0, 0, 0, acc);

        // ALU streaming while four loads fill the FIFO; ALU then stalls.
        for (int i = 1; i <= 4; i++) step(1, 5'd9, 32'h900 + i, 1, 5'(i), 32'(i * 16), acc);
        pend = 1'b1; prd = 5'd10; pdat = 32'hA5A5;
        guard = 0;
        while (guard < 12) begin
            step(1, prd, pdat, 0, 0, 0, acc);
            if (acc) begin
                prd = prd + 5'd1; pdat = pdat + 32'd1;
            end
            guard++;
        end
        step(0, 0, 0, 0, 0, 0, acc);

        // x0 results from both sources are consumed without a write.
        step(1, 5'd0, 32'h1234, 1, 5'd0, 32'h5678, acc);
        repeat (3) step(0, 0, 0, 0, 0, 0, acc);

        // Nine back-to-back loads: push and pop overlap and pointers wrap.
        step(1, 5'd3, 32'h1, 1, 5'd1, 32'h100, acc);
        step(1, 5'd3, 32'h2, 1, 5'd2, 32'h200, acc);
        for (int i = 3; i <= 9; i++) step(0, 0, 0, 1, 5'(i), 32'(i * 256), acc);
        repeat (4) step(0, 0, 0, 0, 0, 0, acc);

`ifdef WB_BYPASS_EN
        rs1 = 5'd7;
        step(1, 5'd7, 32'h77, 0, 0, 0, acc);
        step(0, 0, 0, 0, 0, 0, acc);
        rs1 = 5'd0;
        step(1, 5'd0, 32'h70, 0, 0, 0, acc);
        step(0, 0, 0, 0, 0, 0, acc);
`endif

        // Three queued loads behind a busy ALU, then reset mid-operation.
        for (int i = 0; i < 3; i++) step(1, 5'd4, 32'h40 + i, 1, 5'(20 + i), 32'hC0 + i, acc);
        @(posedge clk);
        #4;
        alu_valid = 1'b0; ld_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_count", 64'(fifo_count), 64'(0));
        chk("arst_regwren", 64'(regwren), 64'(0));
        chk("arst_rd", 64'(rd), 64'(0));
        chk("arst_ld_ready", 64'(ld_ready), 64'(1));
        lq.delete();
        last_rd = '0; last_data = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) step(0, 0, 0, 0, 0, 0, acc);

        // Randomised traffic against the model.
        pend = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (!pend && ($urandom % 3 != 0)) begin
                pend = 1'b1;
                prd  = ($urandom % 8 == 0) ? 5'd0 : 5'($urandom);
                pdat = $urandom;
            end
            rs1 = ($urandom % 3 == 0) ? last_rd : 5'($urandom);
            rs2 = ($urandom % 3 == 0) ? last_rd : 5'($urandom);
            step(pend, prd, pdat, 1'($urandom % 2),
                 ($urandom % 8 == 0) ? 5'd0 : 5'($urandom), $urandom, acc);
            if (acc) pend = 1'b0;
        end
        repeat (DEPTH + 2) step(0, 0, 0, 0, 0, 0, acc);
        @(posedge clk);
        #3;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        chk("final_count", 64'(fifo_count), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
